// File: rtl/cmos_rgb565_capture.sv
`default_nettype none
// ============================================================================
// Module   : cmos_rgb565_capture
// Purpose  : DVP camera capture front-end. Pairs RGB565 bytes (high byte
//            first) into pixels, expands them to RGB888, emits a one-cycle
//            clken per pixel, and suppresses the first CMOS_FRAME_WAITCNT
//            frames after reset while the sensor settles.
// Ports    : clk               camera pixel clock (rising edge)
//            rst_n             asynchronous active-low reset
//            cmos_vsync        sensor vsync, active-high frame-start pulse
//            cmos_href         sensor href, high during active line bytes
//            cmos_data[7:0]    sensor byte stream
//            post_frame_vsync  gated vsync, delayed 2 cycles
//            post_frame_href   gated href, delayed 2 cycles
//            post_frame_clken  one-cycle strobe per assembled pixel
//            post_img_red/green/blue[7:0]  expanded colour, held between strobes
//            frame_valid       sticky, high once suppression has ended
// Revision : 1.0 - initial release
// ============================================================================
module cmos_rgb565_capture #(
  parameter int CMOS_FRAME_WAITCNT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmos_vsync,
  input  logic       cmos_href,
  input  logic [7:0] cmos_data,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue,
  output logic       frame_valid
);

  localparam logic [7:0] c_wait_cnt = 8'(CMOS_FRAME_WAITCNT);

  // Stage 0 input registers and vsync edge history
  logic       vsync_r0_q, href_r0_q, vsync_r1_q;
  logic [7:0] data_r0_q;

  // Frame suppression
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       frame_valid_q, frame_valid_d;

  // Byte pairing
  logic       byte_flag_q, byte_flag_d;
  logic [7:0] hi_byte_q, hi_byte_d;

  // Output stage
  logic       post_vsync_q, post_vsync_d;
  logic       post_href_q, post_href_d;
  logic       post_clken_q, post_clken_d;
  logic [7:0] red_q, red_d;
  logic [7:0] green_q, green_d;
  logic [7:0] blue_q, blue_d;

  logic        w_vsync_rise;
  logic        w_pixel_strobe;
  logic [15:0] w_pixel;

  assign w_vsync_rise   = vsync_r0_q & ~vsync_r1_q;
  // Second byte of a pair is sitting in the r0 register while byte_flag is 1.
  assign w_pixel_strobe = href_r0_q & byte_flag_q;
  assign w_pixel        = {hi_byte_q, data_r0_q};

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (w_vsync_rise && (frame_cnt_q != c_wait_cnt)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    // A rise seen while the counter is already saturated starts the first
    // passed frame.
    frame_valid_d = frame_valid_q | (w_vsync_rise & (frame_cnt_q == c_wait_cnt));

    // Any href-low cycle restarts pairing, dropping a dangling odd byte.
    byte_flag_d = href_r0_q ? ~byte_flag_q : 1'b0;
    hi_byte_d   = (href_r0_q && !byte_flag_q) ? data_r0_q : hi_byte_q;

    // Gating uses the next-state valid so that the output registers are
    // consistent with frame_valid in every cycle; the first passed frame
    // therefore keeps its complete vsync pulse.
    post_vsync_d = frame_valid_d & vsync_r0_q;
    post_href_d  = frame_valid_d & href_r0_q;
    post_clken_d = frame_valid_d & w_pixel_strobe;

    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (!frame_valid_d) begin
      red_d   = 8'h00;
      green_d = 8'h00;
      blue_d  = 8'h00;
    end else if (w_pixel_strobe) begin
      // Replicate the MSBs into the low bits so full-scale maps to 0xFF.
      red_d   = {w_pixel[15:11], w_pixel[15:13]};
      green_d = {w_pixel[10:5],  w_pixel[10:9]};
      blue_d  = {w_pixel[4:0],   w_pixel[4:2]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r0_q    <= 1'b0;
      href_r0_q     <= 1'b0;
      data_r0_q     <= 8'h00;
      vsync_r1_q    <= 1'b0;
      frame_cnt_q   <= 8'h00;
      frame_valid_q <= 1'b0;
      byte_flag_q   <= 1'b0;
      hi_byte_q     <= 8'h00;
      post_vsync_q  <= 1'b0;
      post_href_q   <= 1'b0;
      post_clken_q  <= 1'b0;
      red_q         <= 8'h00;
      green_q       <= 8'h00;
      blue_q        <= 8'h00;
    end else begin
      vsync_r0_q    <= cmos_vsync;
      href_r0_q     <= cmos_href;
      data_r0_q     <= cmos_data;
      vsync_r1_q    <= vsync_r0_q;
      frame_cnt_q   <= frame_cnt_d;
      frame_valid_q <= frame_valid_d;
      byte_flag_q   <= byte_flag_d;
      hi_byte_q     <= hi_byte_d;
      post_vsync_q  <= post_vsync_d;
      post_href_q   <= post_href_d;
      post_clken_q  <= post_clken_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign post_frame_vsync = post_vsync_q;
  assign post_frame_href  = post_href_q;
  assign post_frame_clken = post_clken_q;
  assign post_img_red     = red_q;
  assign post_img_green   = green_q;
  assign post_img_blue    = blue_q;
  assign frame_valid      = frame_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cmos_rgb565_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_rgb565_capture
// Purpose  : Self-checking bench for cmos_rgb565_capture. Two instances
//            (WAITCNT=0 and WAITCNT=2) share one stimulus stream; a stream-
//            level reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_rgb565_capture;

  logic       clk;
  logic       rst_n;
  logic       cmos_vsync;
  logic       cmos_href;
  logic [7:0] cmos_data;

  logic       vs0, hr0, ck0, fv0, vs2, hr2, ck2, fv2;
  logic [7:0] r0, g0, b0, r2, g2, b2;

  int tests = 0;
  int fails = 0;

  cmos_rgb565_capture #(.CMOS_FRAME_WAITCNT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .post_frame_vsync(vs0), .post_frame_href(hr0),
    .post_frame_clken(ck0), .post_img_red(r0), .post_img_green(g0),
    .post_img_blue(b0), .frame_valid(fv0)
  );

  cmos_rgb565_capture #(.CMOS_FRAME_WAITCNT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .post_frame_vsync(vs2), .post_frame_href(hr2),
    .post_frame_clken(ck2), .post_img_red(r2), .post_img_green(g2),
    .post_img_blue(b2), .frame_valid(fv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------- model
  // Expected outputs packed as {vsync, href, clken, frame_valid, r, g, b}.
  int          wc[2] = '{0, 2};
  logic        m_prev_vs[2];
  int          m_rises[2];
  int          m_run[2];
  logic [7:0]  m_hi[2];
  logic [23:0] m_img[2];
  logic [27:0] m_pend[2];
  logic [27:0] m_cur[2];

  function automatic logic [23:0] expand(input logic [15:0] pix);
    int rr, gg, bb;
    rr = int'(pix[15:11]);
    gg = int'(pix[10:5]);
    bb = int'(pix[4:0]);
    return {8'(rr * 8 + rr / 4), 8'(gg * 4 + gg / 16), 8'(bb * 8 + bb / 4)};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_prev_vs[m] = 1'b0; m_rises[m] = 0; m_run[m] = 0; m_hi[m] = 8'h00;
      m_img[m] = 24'h0; m_pend[m] = 28'h0; m_cur[m] = 28'h0;
    end
  endtask

  // Called once per clock edge with the inputs the DUT just sampled; the
  // result appears on the outputs one edge later (two cycles after input).
  task automatic model_update(input logic vs, input logic hr, input logic [7:0] d);
    logic        valid, strobe;
    logic [15:0] pix;
    for (int m = 0; m < 2; m++) begin
      m_cur[m] = m_pend[m];
      if (vs && !m_prev_vs[m]) m_rises[m]++;
      m_prev_vs[m] = vs;
      valid  = (m_rises[m] > wc[m]);
      strobe = 1'b0;
      pix    = 16'h0;
      if (hr) begin
        m_run[m]++;
        if (m_run[m] % 2 == 0) begin
          strobe = 1'b1;
          pix    = {m_hi[m], d};
        end else begin
          m_hi[m] = d;
        end
      end else begin
        m_run[m] = 0;
      end
      if (!valid) m_img[m] = 24'h0;
      else if (strobe) m_img[m] = expand(pix);
      m_pend[m] = {valid & vs, valid & hr, valid & strobe, valid, m_img[m]};
    end
  endtask

  function automatic logic [27:0] got0();
    return {vs0, hr0, ck0, fv0, r0, g0, b0};
  endfunction

  function automatic logic [27:0] got2();
    return {vs2, hr2, ck2, fv2, r2, g2, b2};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, got, exp);
    end
  endtask

  task automatic check_model();
    chk("model_w0", {4'h0, got0()}, {4'h0, m_cur[0]});
    chk("model_w2", {4'h0, got2()}, {4'h0, m_cur[1]});
  endtask

  // --------------------------------------------------------------- driving
  logic        collect = 1'b0;
  logic [23:0] pix_q[$];
  int          ck2_cnt = 0;

  // Entered and left on a falling edge.
  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    check_model();
    if (collect && ck0) pix_q.push_back({r0, g0, b0});
    if (ck2) ck2_cnt++;
    cmos_vsync = vs;
    cmos_href  = hr;
    cmos_data  = d;
    @(posedge clk);
    model_update(vs, hr, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'h00;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_model();
    end
    rst_n = 1'b1;
  endtask

  task automatic frame(input int nlines, input int nbytes);
    step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'($urandom));
    for (int l = 0; l < nlines; l++) begin
      for (int b = 0; b < nbytes; b++) step(1'b0, 1'b1, 8'($urandom));
      step(1'b0, 1'b0, 8'($urandom));
      step(1'b0, 1'b0, 8'($urandom));
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic       vs, hr;
    logic [7:0] d;
    logic       evs, ehr, eck;
    logic [23:0] rgb;
  } row_t;

  row_t tbl[13];
  logic vh[2], hh[2];
  logic rv, rh;

  initial begin
    // Expected columns are the WAITCNT=0 outputs seen before the row's
    // inputs are driven (i.e. the effect of the row two entries earlier).
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[2]  = '{1'b0, 1'b1, 8'hF8, 1'b1, 1'b0, 1'b0, 24'h000000};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[4]  = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[5]  = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b1, 1'b1, 24'hFF0000};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 24'hFF0000};
    tbl[7]  = '{1'b0, 1'b1, 8'h1F, 1'b0, 1'b1, 1'b1, 24'h00FF00};
    tbl[8]  = '{1'b0, 1'b1, 8'h84, 1'b0, 1'b1, 1'b0, 24'h00FF00};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 24'h0000FF};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 24'h0000FF};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 24'h848284};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 24'h848284};

    rst_n = 1'b0;
    cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'h00;
    model_reset();

    // Reset state and single-line RGB table with WAITCNT=0.
    do_reset();
    chk("reset_fv0", {31'h0, fv0}, 32'h0);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl_row%0d", i), {8'h0, vs0, hr0, ck0, 5'h0, r0, g0, b0},
          {8'h0, tbl[i].evs, tbl[i].ehr, tbl[i].eck, 5'h0, tbl[i].rgb});
      step(tbl[i].vs, tbl[i].hr, tbl[i].d);
    end

    // WAITCNT=2: frames 1 and 2 suppressed, frame 3 passes.
    do_reset();
    frame(1, 4);
    chk("w2_fv_after_f1", {31'h0, fv2}, 32'h0);
    frame(1, 4);
    chk("w2_fv_after_f2", {31'h0, fv2}, 32'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("w2_fv_rise_cycle", {31'h0, fv2}, 32'h0);
    step(1'b1, 1'b0, 8'h00);
    chk("w2_fv_after_rise", {31'h0, fv2}, 32'h1);
    chk("w2_vsync_passed", {31'h0, vs2}, 32'h1);
    step(1'b0, 1'b0, 8'h00);
    ck2_cnt = 0;
    for (int b = 0; b < 4; b++) step(1'b0, 1'b1, 8'($urandom));
    repeat (3) step(1'b0, 1'b0, 8'h00);
    chk("w2_f3_clken_count", ck2_cnt, 2);

    // Odd-length line: trailing byte dropped, next line starts fresh.
    pix_q.delete();
    collect = 1'b1;
    step(1'b0, 1'b1, 8'hF8); step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'hF8); step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'hAA); step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b1, 8'h1F);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    collect = 1'b0;
    chk("odd_pulse_count", pix_q.size(), 3);
    if (pix_q.size() == 3) begin
      chk("odd_pix0", {8'h0, pix_q[0]}, 32'h00FF0000);
      chk("odd_pix1", {8'h0, pix_q[1]}, 32'h00FF0000);
      chk("odd_pix2", {8'h0, pix_q[2]}, 32'h000000FF);
    end

    // Random vsync/href/data; also check the 2-cycle delay directly.
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    vh = '{1'b0, 1'b0};
    hh = '{1'b0, 1'b0};
    for (int i = 0; i < 300; i++) begin
      rv = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      chk("delay_vsync", {31'h0, vs0}, {31'h0, vh[1]});
      chk("delay_href", {31'h0, hr0}, {31'h0, hh[1]});
      vh[1] = vh[0]; vh[0] = rv;
      hh[1] = hh[0]; hh[0] = rh;
      step(rv, rh, 8'($urandom));
    end

    // Mid-line reset during frame 3 with WAITCNT=2.
    do_reset();
    frame(1, 4);
    frame(1, 4);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hF8);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h07);
    step(1'b0, 1'b1, 8'hE0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_w0", {4'h0, got0()}, 32'h0);
    chk("async_rst_w2", {4'h0, got2()}, 32'h0);
    cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'h00;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_model();
    end
    rst_n = 1'b1;
    frame(1, 4);
    chk("rst_fv2_after_f1", {31'h0, fv2}, 32'h0);
    chk("rst_fv0_after_f1", {31'h0, fv0}, 32'h1);
    frame(1, 4);
    chk("rst_fv2_after_f2", {31'h0, fv2}, 32'h0);
    frame(2, 6);
    chk("rst_fv2_after_f3", {31'h0, fv2}, 32'h1);
    step(1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
